lzw_pack: RTL and testbench

LZW_PACK -- requirements
Module: lzw_pack

---
 rtl/lzw_pack.sv | 136 +++++++++++++
 tb/tb_lzw_pack.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lzw_pack.sv
// rtl/lzw_pack.sv - MSB-first variable-width LZW code packer into fixed-width symbols
//
// Ports:
//   clk, rst_n                        clock, synchronous active-low reset
//   code_valid/code_ready             code input handshake
//   code_data[MAX_CODE_W]             right-justified code, bits above code_width ignored
//   code_width[5]                     runtime width sampled with each accepted code
//   flush_req                         pad to a symbol boundary and drain everything held
//   out_valid/out_ready               symbol output handshake
//   out_data[OUT_W]                   top OUT_W bits of the accumulator
//   out_last                          final zero-padded symbol of a flush
//   flush_done                        one-cycle pulse when a drain completes
//   width_err                         sticky: an accepted width was outside 9..MAX_CODE_W
module lzw_pack #(
  parameter int MAX_CODE_W = 13,
  parameter int OUT_W      = 8,
  parameter int ACC_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  code_valid,
  output logic                  code_ready,
  input  logic [MAX_CODE_W-1:0] code_data,
  input  logic [4:0]            code_width,
  input  logic                  flush_req,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_W-1:0]      out_data,
  output logic                  out_last,
  output logic                  flush_done,
  output logic                  width_err
);

  localparam int CW = $clog2(ACC_W + 1);

  localparam logic [CW-1:0] C_ACC     = CW'(ACC_W);
  localparam logic [CW-1:0] C_OUT     = CW'(OUT_W);
  localparam logic [CW-1:0] C_MAXW    = CW'(MAX_CODE_W);
  localparam logic [CW-1:0] C_RDY_MAX = CW'(ACC_W - MAX_CODE_W);
  localparam logic [4:0]    W_MIN5    = 5'd9;
  localparam logic [4:0]    W_MAX5    = 5'(MAX_CODE_W);

  typedef enum logic {
    S_RUN   = 1'b0,
    S_DRAIN = 1'b1
  } state_t;

  state_t           r_state;
  logic [ACC_W-1:0] r_acc;
  logic [CW-1:0]    r_cnt;
  logic             r_code_ready;
  logic             r_out_valid;
  logic             r_out_last;
  logic             r_flush_done;
  logic             r_width_err;

  logic                  w_width_ok;
  logic [CW-1:0]         w_weff;
  logic [MAX_CODE_W-1:0] w_code_m;
  logic [ACC_W-1:0]      w_code_ext;
  logic                  w_pop;
  logic                  w_push;
  logic [ACC_W-1:0]      w_acc_p;
  logic [CW-1:0]         w_cnt_p;
  logic [CW-1:0]         w_shamt;
  logic [ACC_W-1:0]      w_acc_n;
  logic [CW-1:0]         w_cnt_n;
  state_t                w_state_n;

  always_comb begin
    w_width_ok = (code_width >= W_MIN5) && (code_width <= W_MAX5);
    w_weff     = w_width_ok ? CW'(code_width) : C_MAXW;

    for (int i = 0; i < MAX_CODE_W; i++) begin
      w_code_m[i] = code_data[i] & (i < int'(w_weff));
    end
    w_code_ext = ACC_W'(w_code_m);

    w_pop  = r_out_valid & out_ready;
    w_push = r_code_ready & code_valid;

    // Pop first so a same-cycle push lands right behind the surviving bits.
    w_acc_p = w_pop ? (r_acc << OUT_W) : r_acc;
    if (w_pop) begin
      w_cnt_p = (r_cnt > C_OUT) ? (r_cnt - C_OUT) : '0;
    end else begin
      w_cnt_p = r_cnt;
    end

    // code_ready guarantees cnt' + w <= ACC_W, so the shift is never negative.
    w_shamt = C_ACC - w_cnt_p - w_weff;
    w_acc_n = w_push ? (w_acc_p | (w_code_ext << w_shamt)) : w_acc_p;
    w_cnt_n = w_push ? (w_cnt_p + w_weff) : w_cnt_p;

    w_state_n = r_state;
    case (r_state)
      S_RUN:   if (flush_req) w_state_n = S_DRAIN;
      // Leave DRAIN one cycle after the count hits zero; that cycle carries flush_done.
      S_DRAIN: if (r_cnt == '0) w_state_n = S_RUN;
      default: w_state_n = S_RUN;
    endcase
  end

  // Outputs are registered from the next-state values so they line up with r_acc/r_cnt.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_RUN;
      r_acc        <= '0;
      r_cnt        <= '0;
      r_code_ready <= 1'b1;
      r_out_valid  <= 1'b0;
      r_out_last   <= 1'b0;
      r_flush_done <= 1'b0;
      r_width_err  <= 1'b0;
    end else begin
      r_state      <= w_state_n;
      r_acc        <= w_acc_n;
      r_cnt        <= w_cnt_n;
      r_code_ready <= (w_state_n == S_RUN) && (w_cnt_n <= C_RDY_MAX);
      r_out_valid  <= (w_state_n == S_RUN) ? (w_cnt_n >= C_OUT) : (w_cnt_n != '0);
      r_out_last   <= (w_state_n == S_DRAIN) && (w_cnt_n != '0) && (w_cnt_n <= C_OUT);
      r_flush_done <= (w_state_n == S_DRAIN) && (w_cnt_n == '0);
      if (w_push && !w_width_ok) begin
        r_width_err <= 1'b1;
      end
    end
  end

  assign code_ready = r_code_ready;
  assign out_valid  = r_out_valid;
  assign out_data   = r_acc[ACC_W-1 -: OUT_W];
  assign out_last   = r_out_last;
  assign flush_done = r_flush_done;
  assign width_err  = r_width_err;

endmodule

// File: tb/tb_lzw_pack.sv
// tb/tb_lzw_pack.sv - self-checking bench for lzw_pack
module tb_lzw_pack;

  logic        clk;
  logic        rst_n;
  logic        code_valid;
  logic        code_ready;
  logic [12:0] code_data;
  logic [4:0]  code_width;
  logic        flush_req;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_last;
  logic        flush_done;
  logic        width_err;

  lzw_pack #(.MAX_CODE_W(13), .OUT_W(8), .ACC_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .code_data  (code_data),
    .code_width (code_width),
    .flush_req  (flush_req),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .flush_done (flush_done),
    .width_err  (width_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  int         cyc = 0;
  logic [7:0] q_data[$];
  logic       q_last[$];
  int         fd_cnt;
  int         fd_cyc;
  int         last_pop_cyc;
  int         both_cnt;

  always @(posedge clk) cyc <= cyc + 1;

  // Observe handshakes mid-cycle; they complete on the following rising edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        q_data.push_back(out_data);
        q_last.push_back(out_last);
        last_pop_cyc = cyc;
        if (code_valid && code_ready) both_cnt++;
      end
      if (flush_done) begin
        fd_cnt++;
        fd_cyc = cyc;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    code_valid = 1'b0;
    code_data  = '0;
    code_width = 5'd13;
    flush_req  = 1'b0;
    out_ready  = 1'b0;
    step();
    step();
    q_data.delete();
    q_last.delete();
    fd_cnt       = 0;
    fd_cyc       = -100;
    last_pop_cyc = -200;
    both_cnt     = 0;
    rst_n        = 1'b1;
  endtask

  task automatic push_code(input logic [4:0] w, input logic [12:0] c, input bit fl);
    code_valid = 1'b1;
    code_width = w;
    code_data  = c;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (code_ready) break;
    end
    chk("push_accept", {31'd0, code_ready}, 32'd1);
    flush_req = fl;
    step();
    code_valid = 1'b0;
    flush_req  = 1'b0;
  endtask

  typedef struct {
    logic [4:0]  w;
    int          ncode;
    logic [12:0] c0;
    logic [12:0] c1;
    int          nsym;
    logic [31:0] syms;
    logic        err;
  } vec_t;

  vec_t tbl[8];

  logic [12:0] s_codes[10];
  bit          ref_bits[$];
  logic [7:0]  ref_bytes[$];
  logic [7:0]  b;
  int          acc_n;
  int          seen;
  int          stable_bad;

  initial begin
    tbl[0] = '{5'd13, 1, 13'h1ABC, 13'h0000, 2, 32'hD5E0_0000, 1'b0};
    tbl[1] = '{5'd9,  2, 13'h01FF, 13'h0000, 3, 32'hFF80_0000, 1'b0};
    tbl[2] = '{5'd13, 2, 13'h1ABC, 13'h0155, 4, 32'hD5E0_5540, 1'b0};
    tbl[3] = '{5'd12, 1, 13'h1ABC, 13'h0000, 2, 32'hABC0_0000, 1'b0};
    tbl[4] = '{5'd20, 1, 13'h0AAA, 13'h0000, 2, 32'h5550_0000, 1'b1};
    tbl[5] = '{5'd8,  1, 13'h0123, 13'h0000, 2, 32'h0918_0000, 1'b1};
    tbl[6] = '{5'd10, 1, 13'h03FF, 13'h0000, 2, 32'hFFC0_0000, 1'b0};
    tbl[7] = '{5'd11, 1, 13'h05A5, 13'h0000, 2, 32'hB4A0_0000, 1'b0};

    // Reset state
    do_reset();
    @(negedge clk);
    chk("rst_out_valid",  {31'd0, out_valid},  32'd0);
    chk("rst_out_last",   {31'd0, out_last},   32'd0);
    chk("rst_flush_done", {31'd0, flush_done}, 32'd0);
    chk("rst_out_data",   {24'd0, out_data},   32'd0);
    chk("rst_code_ready", {31'd0, code_ready}, 32'd1);
    chk("rst_width_err",  {31'd0, width_err},  32'd0);

    // Table: one or two codes, flush with the last push, drain freely.
    for (int v = 0; v < 8; v++) begin
      do_reset();
      out_ready = 1'b1;
      push_code(tbl[v].w, tbl[v].c0, tbl[v].ncode == 1);
      if (tbl[v].ncode == 2) push_code(tbl[v].w, tbl[v].c1, 1'b1);
      repeat (12) step();
      chk($sformatf("v%0d_nsym", v), q_data.size(), tbl[v].nsym);
      for (int j = 0; j < tbl[v].nsym; j++) begin
        if (j < q_data.size()) begin
          chk($sformatf("v%0d_sym%0d", v, j), {24'd0, q_data[j]}, {24'd0, tbl[v].syms[31-8*j -: 8]});
          chk($sformatf("v%0d_last%0d", v, j), {31'd0, q_last[j]}, {31'd0, (j == tbl[v].nsym - 1)});
        end
      end
      chk($sformatf("v%0d_fd_cnt", v), fd_cnt, 1);
      chk($sformatf("v%0d_fd_timing", v), fd_cyc - last_pop_cyc, 1);
      chk($sformatf("v%0d_width_err", v), {31'd0, width_err}, {31'd0, tbl[v].err});
    end

    // Backpressure: only two 13-bit codes fit, head symbol holds still.
    do_reset();
    out_ready  = 1'b0;
    code_valid = 1'b1;
    code_width = 5'd13;
    code_data  = 13'h1ABC;
    acc_n = 0;
    seen = 0;
    stable_bad = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (code_valid && code_ready) acc_n++;
      if (out_valid) begin
        seen++;
        if (out_data !== 8'hD5 || out_last !== 1'b0) stable_bad++;
      end
      step();
    end
    code_valid = 1'b0;
    @(negedge clk);
    chk("stall_accepted", acc_n, 2);
    chk("stall_code_ready", {31'd0, code_ready}, 32'd0);
    chk("stall_seen", seen, 5);
    chk("stall_stable", stable_bad, 0);

    // Flush into DRAIN, pop two of four symbols, then reset mid-drain.
    step();
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    out_ready = 1'b0;
    chk("drain_pops", q_data.size(), 2);
    if (q_data.size() >= 2) begin
      chk("drain_b0", {24'd0, q_data[0]}, 32'hD5);
      chk("drain_b1", {24'd0, q_data[1]}, 32'hE6);
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_out_valid",  {31'd0, out_valid},  32'd0);
    chk("mid_rst_out_last",   {31'd0, out_last},   32'd0);
    chk("mid_rst_flush_done", {31'd0, flush_done}, 32'd0);
    chk("mid_rst_code_ready", {31'd0, code_ready}, 32'd1);
    chk("mid_rst_out_data",   {24'd0, out_data},   32'd0);
    out_ready = 1'b1;
    repeat (5) step();
    chk("mid_rst_no_fd", fd_cnt, 0);
    chk("mid_rst_no_sym", q_data.size(), 2);

    // Streaming with simultaneous push and pop against a reference bit stream.
    do_reset();
    out_ready = 1'b1;
    ref_bits.delete();
    ref_bytes.delete();
    for (int i = 0; i < 10; i++) begin
      s_codes[i] = 13'((i * 32'h3A7) + 32'h111);
      for (int k = 12; k >= 0; k--) ref_bits.push_back(s_codes[i][k]);
    end
    while (ref_bits.size() % 8 != 0) ref_bits.push_back(1'b0);
    for (int i = 0; i < ref_bits.size() / 8; i++) begin
      for (int k = 0; k < 8; k++) b[7-k] = ref_bits[8*i + k];
      ref_bytes.push_back(b);
    end
    for (int i = 0; i < 10; i++) push_code(5'd13, s_codes[i], i == 9);
    repeat (12) step();
    chk("stream_nbytes", q_data.size(), ref_bytes.size());
    for (int i = 0; i < ref_bytes.size(); i++) begin
      if (i < q_data.size()) begin
        chk($sformatf("stream_b%0d", i), {24'd0, q_data[i]}, {24'd0, ref_bytes[i]});
        chk($sformatf("stream_last%0d", i), {31'd0, q_last[i]}, {31'd0, (i == ref_bytes.size() - 1)});
      end
    end
    chk("stream_overlap", {31'd0, (both_cnt > 0)}, 32'd1);
    chk("stream_fd_cnt", fd_cnt, 1);

    // Flush with nothing held.
    do_reset();
    out_ready = 1'b1;
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    @(negedge clk);
    chk("empty_fd_now", {31'd0, flush_done}, 32'd1);
    chk("empty_no_valid", {31'd0, out_valid}, 32'd0);
    chk("empty_drain_ready", {31'd0, code_ready}, 32'd0);
    repeat (5) step();
    chk("empty_fd_cnt", fd_cnt, 1);
    chk("empty_no_sym", q_data.size(), 0);
    chk("empty_ready_back", {31'd0, code_ready}, 32'd1);

    // width_err is sticky until reset.
    push_code(5'd20, 13'h0AAA, 1'b0);
    @(negedge clk);
    chk("werr_set", {31'd0, width_err}, 32'd1);
    step();
    push_code(5'd13, 13'h0001, 1'b0);
    @(negedge clk);
    chk("werr_sticky", {31'd0, width_err}, 32'd1);
    do_reset();
    @(negedge clk);
    chk("werr_cleared", {31'd0, width_err}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
